// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions: resolve-unit FSM encoding, fall-through
// PC steps and the 2-bit predictor counter states.
package bp_pkg;

   typedef enum logic {
      BRU_IDLE     = 1'b0,
      BRU_REDIRECT = 1'b1
   } bru_state_t;

   localparam int PC_STEP_DS = 8;
   localparam int PC_STEP    = 4;

   // 2-bit saturating predictor states, shared with the predictor
   localparam logic [1:0] BP_STRONG_NT = 2'b00;
   localparam logic [1:0] BP_WEAK_NT   = 2'b01;
   localparam logic [1:0] BP_WEAK_T    = 2'b10;
   localparam logic [1:0] BP_STRONG_T  = 2'b11;

   function automatic int fallthrough_step(input int delay_slot);
      return (delay_slot != 0) ? PC_STEP_DS : PC_STEP;
   endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones instead of wrapping.
module bp_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         r_cnt <= '0;
      else if (inc && (r_cnt != {CNT_W{1'b1}}))
         r_cnt <= r_cnt + 1'b1;
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries the decode prediction D->E->M, resolves it in M (predictor update, flush,
// fetch redirect over valid/ready). Optional perf counters under BRU_PERF_CNT_EN.
module branch_resolve_unit
   import bp_pkg::*;
#(
   parameter int PC_W       = 32,
   parameter int DELAY_SLOT = 1,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallE,
   input  logic             flushE,
   input  logic             stallM,
   input  logic             branchD,
   input  logic             pred_takeD,
   input  logic [PC_W-1:0]  pcD,
   input  logic [PC_W-1:0]  targetD,
   input  logic             actual_takeE,
   output logic             upd_valid,
   output logic [PC_W-1:0]  upd_pc,
   output logic             upd_taken,
   output logic             flush_req,
   output logic             redirect_valid,
   output logic [PC_W-1:0]  redirect_pc,
   input  logic             redirect_ready,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] mis_cnt
);

   localparam logic [PC_W-1:0] LP_FT_STEP = PC_W'(fallthrough_step(DELAY_SLOT));

   logic            r_validE, r_branchE, r_predE;
   logic [PC_W-1:0] r_pcE, r_tgtE;
   logic            r_validM, r_branchM, r_predM, r_actM;
   logic [PC_W-1:0] r_pcM, r_tgtM;
   bru_state_t      r_state;
   logic [PC_W-1:0] r_redirect_pc;
   logic            w_res, w_mis;

   always_ff @(posedge clk) begin
      if (rst || flushE) begin
         r_validE  <= 1'b0;
         r_branchE <= 1'b0;
         r_predE   <= 1'b0;
         r_pcE     <= '0;
         r_tgtE    <= '0;
      end else if (!stallE) begin
         r_validE  <= 1'b1;
         r_branchE <= branchD;
         r_predE   <= pred_takeD;
         r_pcE     <= pcD;
         r_tgtE    <= targetD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_validM  <= 1'b0;
         r_branchM <= 1'b0;
         r_predM   <= 1'b0;
         r_actM    <= 1'b0;
         r_pcM     <= '0;
         r_tgtM    <= '0;
      end else if (!stallM) begin
         r_validM  <= r_validE;
         r_branchM <= r_branchE;
         r_predM   <= r_predE;
         r_actM    <= actual_takeE;
         r_pcM     <= r_pcE;
         r_tgtM    <= r_tgtE;
      end
   end

   // A branch resolves only on the cycle it leaves M, and never while a redirect is pending
   assign w_res = r_validM & r_branchM & ~stallM & (r_state == BRU_IDLE);
   assign w_mis = w_res & (r_predM != r_actM);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= BRU_IDLE;
         r_redirect_pc <= '0;
      end else begin
         case (r_state)
            BRU_IDLE: begin
               if (w_mis) begin
                  r_state       <= BRU_REDIRECT;
                  r_redirect_pc <= r_actM ? r_tgtM : (r_pcM + LP_FT_STEP);
               end
            end
            BRU_REDIRECT: begin
               if (redirect_ready)
                  r_state <= BRU_IDLE;
            end
            default: r_state <= BRU_IDLE;
         endcase
      end
   end

   assign upd_valid      = w_res;
   assign upd_pc         = r_pcM;
   assign upd_taken      = r_actM;
   assign flush_req      = w_mis;
   assign redirect_valid = (r_state == BRU_REDIRECT);
   assign redirect_pc    = r_redirect_pc;

`ifdef BRU_PERF_CNT_EN
   bp_sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_res),
      .cnt (br_cnt)
   );

   bp_sat_counter #(.CNT_W(CNT_W)) u_mis_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_mis),
      .cnt (mis_cnt)
   );
`else
   assign br_cnt  = '0;
   assign mis_cnt = '0;
`endif

endmodule
